// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select and one-hot grant of a shared 4-bit 4:1 bus mux.
// Optional per-ownership hold timeout is enabled by defining MUX_HOLD_TIMEOUT_EN.
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  output logic [3:0] o_grant,
  output logic [1:0] o_sel,
  output logic       o_busy
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     r_state;
  state_e     w_state_d;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_d;
  logic [1:0] r_sel;
  logic [1:0] w_sel_d;
  logic [3:0] r_grant;
  logic [3:0] w_grant_d;
  logic       r_busy;
  logic       w_busy_d;

  logic [3:0] w_rot;
  logic [1:0] w_off;
  logic [1:0] w_pick;
  logic       w_any;
  logic       w_timeout;
  logic       w_release;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_check
    $error("MAX_HOLD must be in 1..255");
  end

  // Rotate requests so bit k is requester (ptr + k) mod 4; lowest set bit wins.
  always_comb begin
    w_rot = i_req;
    case (r_ptr)
      2'd0:    w_rot = i_req;
      2'd1:    w_rot = {i_req[0],   i_req[3:1]};
      2'd2:    w_rot = {i_req[1:0], i_req[3:2]};
      default: w_rot = {i_req[2:0], i_req[3]};
    endcase
  end

  always_comb begin
    w_off = 2'd3;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
  end

  assign w_any  = |i_req;
  assign w_pick = r_ptr + w_off;

`ifdef MUX_HOLD_TIMEOUT_EN
  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  logic [7:0] r_hold;

  // Zero throughout IDLE, so the first GRANT cycle always sees a cleared count.
  always_ff @(posedge i_clk) begin
    if (i_rst || r_state == StIdle) begin
      r_hold <= 8'd0;
    end else begin
      r_hold <= r_hold + 8'd1;
    end
  end

  assign w_timeout = (r_hold == HoldLast);
`else
  assign w_timeout = 1'b0;
`endif

  // Owner index is held in r_sel for the whole GRANT state.
  assign w_release = ~i_req[r_sel] | w_timeout;

  // State register (all outputs are registered alongside the state).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_ptr   <= 2'd0;
      r_sel   <= 2'd0;
      r_grant <= 4'b0000;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_sel   <= w_sel_d;
      r_grant <= w_grant_d;
      r_busy  <= w_busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_any)     w_state_d = StGrant;
      StGrant: if (w_release) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    w_grant_d = r_grant;
    w_sel_d   = r_sel;
    w_busy_d  = r_busy;
    w_ptr_d   = r_ptr;
    unique case (r_state)
      StIdle: begin
        if (w_any) begin
          w_grant_d = 4'b0001 << w_pick;
          w_sel_d   = w_pick;
          w_busy_d  = 1'b1;
        end
      end
      StGrant: begin
        if (w_release) begin
          w_grant_d = 4'b0000;
          w_busy_d  = 1'b0;
          w_ptr_d   = r_sel + 2'd1;
        end
      end
      default: begin
        w_grant_d = 4'b0000;
        w_busy_d  = 1'b0;
      end
    endcase
  end

  assign o_grant = r_grant;
  assign o_sel   = r_sel;
  assign o_busy  = r_busy;

  a_grant_onehot0 : assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(o_grant));
  a_busy_matches  : assert property (@(posedge i_clk) disable iff (i_rst) o_busy == |o_grant);
  a_sel_is_owner  : assert property (@(posedge i_clk) disable iff (i_rst)
                                     o_busy |-> (o_grant == (4'b0001 << o_sel)));

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: vector table plus hand-written hold-timeout sequence.
module tb_mux_rr_arbiter;

  logic       i_clk;
  logic       i_rst;
  logic [3:0] i_req;
  logic [3:0] o_grant;
  logic [1:0] o_sel;
  logic       o_busy;

  int n_tests;
  int n_fail;

  mux_rr_arbiter #(
    .MAX_HOLD(8)
  ) u_dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_req  (i_req),
    .o_grant(o_grant),
    .o_sel  (o_sel),
    .o_busy (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  localparam int NumVec = 28;
  vec_t vecs [NumVec];

  task automatic check(input string name, input logic [3:0] g, input logic [1:0] s,
                       input logic b);
    n_tests++;
    if (o_grant !== g || o_sel !== s || o_busy !== b) begin
      n_fail++;
      $display("FAIL %s: got grant=%b sel=%0d busy=%b, expected grant=%b sel=%0d busy=%b",
               name, o_grant, o_sel, o_busy, g, s, b);
    end
  endtask

  // Apply inputs at the falling edge, let one rising edge pass, sample at the next falling edge.
  task automatic step(input logic rst, input logic [3:0] req);
    i_rst = rst;
    i_req = req;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    i_rst   = 1'b1;
    i_req   = 4'b0000;

    // {rst, req, expected grant, sel, busy} after the edge
    vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};  // reset overrides requests
    vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};  // requester 0 first after reset
    vecs[3]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
    vecs[4]  = '{1'b0, 4'b1110, 4'b0000, 2'd0, 1'b0};  // drop: idle, sel holds
    vecs[5]  = '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1};  // ptr moved to 1
    vecs[6]  = '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1};
    vecs[7]  = '{1'b0, 4'b1101, 4'b0000, 2'd1, 1'b0};
    vecs[8]  = '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1};
    vecs[9]  = '{1'b0, 4'b1011, 4'b0000, 2'd2, 1'b0};
    vecs[10] = '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1};
    vecs[11] = '{1'b0, 4'b0111, 4'b0000, 2'd3, 1'b0};
    vecs[12] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};  // ptr wrapped 3->0
    vecs[13] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[14] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};  // stays idle
    vecs[15] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};  // single requester 2
    vecs[16] = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0};  // sel keeps 2
    vecs[17] = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0};
    vecs[18] = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1};  // ptr=3, scan 3,0,1
    vecs[19] = '{1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1};  // non-owner ignored
    vecs[20] = '{1'b0, 4'b0001, 4'b0000, 2'd1, 1'b0};  // owner 1 drops
    vecs[21] = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1};  // ptr=2, scan 2,3,0
    vecs[22] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};  // ptr=1
    vecs[23] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
    vecs[24] = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};  // reset mid-grant
    vecs[25] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};  // ptr back to 0
    vecs[26] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[27] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};

    @(negedge i_clk);
    for (int i = 0; i < NumVec; i++) begin
      step(vecs[i].rst, vecs[i].req);
      check($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel, vecs[i].busy);
    end

    // Long hold by requester 0 while requester 2 waits.
    step(1'b1, 4'b0000);
    check("hold_reset", 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b0101);
    check("hold_c0", 4'b0001, 2'd0, 1'b1);
`ifdef MUX_HOLD_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      step(1'b0, 4'b0101);
      check($sformatf("hold_c%0d", k), 4'b0001, 2'd0, 1'b1);
    end
    step(1'b0, 4'b0101);
    check("timeout_idle", 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b0101);
    check("timeout_next", 4'b0100, 2'd2, 1'b1);
`else
    for (int k = 1; k < 52; k++) begin
      step(1'b0, 4'b0101);
      check($sformatf("hold_c%0d", k), 4'b0001, 2'd0, 1'b1);
    end
    step(1'b0, 4'b0100);
    check("hold_drop", 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b0100);
    check("hold_next", 4'b0100, 2'd2, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
